// File: rtl/s_box_sequencer.sv
// s_box_sequencer: fans one 48-bit word out to the eight DES S-boxes
// and gathers their nibbles into the 32-bit substitution word.
module s_box_sequencer #(
  parameter int unsigned SERIAL  = 0,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        err,
  input  logic        err_clr,
  output logic [47:0] sbox_in,
  output logic [7:0]  sbox_select,
  input  logic [7:0]  sbox_finish,
  input  logic [31:0] sbox_out
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, COLLECT, DONE, ERR
  } state_e;

  localparam logic [3:0] TO = 4'(TIMEOUT);
  localparam logic [7:0] FIRST =
    (SERIAL != 0) ? 8'h80 : 8'hFF;

  state_e      state_q, state_d;
  logic [47:0] sin_q, sin_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  pulse_q, pulse_d;
  logic [7:0]  sel_q, sel_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  cap;
  logic [2:0]  k_q, k_d;
  logic [3:0]  cnt_q [8];
  logic [3:0]  cnt_d [8];
  logic        expired;

  always_comb begin
    state_d = state_q;
    sin_d   = sin_q;
    data_d  = data_q;
    pulse_d = '0;
    sel_d   = sel_q;
    mask_d  = mask_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    cap     = '0;
    expired = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sin_d   = in_data;
          data_d  = '0;
          mask_d  = '0;
          pulse_d = FIRST;
          sel_d   = FIRST;
          k_d     = '0;
          for (int i = 0; i < 8; i++)
            cnt_d[i] = '0;
          state_d = ISSUE;
        end
      end
      ISSUE, COLLECT: begin
        // only boxes already selected may report
        cap    = sbox_finish & sel_q & ~mask_q;
        mask_d = mask_q | cap;
        for (int i = 0; i < 8; i++) begin
          if (cap[7-i])
            data_d[31-4*i -: 4] =
              sbox_out[31-4*i -: 4];
          if (sel_q[i] && !pulse_q[i]
              && !mask_d[i]) begin
            cnt_d[i] = cnt_q[i] + 4'd1;
            if (cnt_d[i] == TO)
              expired = 1'b1;
          end
        end
        if (state_q == ISSUE) begin
          if (SERIAL == 0 || k_q == 3'd7) begin
            state_d = COLLECT;
          end else begin
            k_d     = k_q + 3'd1;
            pulse_d = pulse_q >> 1;
            sel_d   = sel_q | (pulse_q >> 1);
          end
        end
        if (expired) begin
          state_d = ERR;
          pulse_d = '0;
        end else if (&mask_d) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      ERR: begin
        if (err_clr)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sin_q   <= '0;
      data_q  <= '0;
      pulse_q <= '0;
      sel_q   <= '0;
      mask_q  <= '0;
      k_q     <= '0;
      for (int i = 0; i < 8; i++)
        cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sin_q   <= sin_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      k_q     <= k_d;
      for (int i = 0; i < 8; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign err         = (state_q == ERR);
  assign out_data    = data_q;
  assign sbox_in     = sin_q;
  assign sbox_select = pulse_q;

endmodule

// File: tb/tb_s_box_sequencer.sv
// tb_s_box_sequencer: drives parallel and serial sequencers against
// registered DES S-box stubs and a table-based substitution model.
module tb_s_box_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] ST [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  function automatic logic [3:0] sbox(input int i, input logic [5:0] x);
    int idx;
    logic [255:0] t;
    idx = int'({x[5], x[0]}) * 16 + int'(x[4:1]);
    t = ST[i];
    return t[255-4*idx -: 4];
  endfunction

  function automatic logic [31:0] ref_sub(input logic [47:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[31-4*i -: 4] = sbox(i, d[47-6*i -: 6]);
    return r;
  endfunction

  function automatic logic [31:0] nm(input logic [7:0] f);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[31-4*i -: 4] = {4{f[7-i]}};
    return r;
  endfunction

  logic        rst_n, mode, in_valid, out_ready, err_clr;
  logic [47:0] in_data;
  logic [7:0]  dead, inj_f;
  logic [31:0] inj_d;

  logic        ir0, ov0, er0, ir1, ov1, er1;
  logic [31:0] od0, od1, so0, so1;
  logic [47:0] sin0, sin1;
  logic [7:0]  sel0, sel1, fn0, fn1;
  logic [31:0] so0_q = '0, so1_q = '0;
  logic [7:0]  fin0_q = '0, fin1_q = '0;
  logic        vld0, vld1;

  assign vld0 = in_valid & ~mode;
  assign vld1 = in_valid & mode;
  assign fn0 = fin0_q | inj_f;
  assign fn1 = fin1_q | inj_f;
  assign so0 = (so0_q & ~nm(inj_f)) | (inj_d & nm(inj_f));
  assign so1 = (so1_q & ~nm(inj_f)) | (inj_d & nm(inj_f));

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (sel0[7-i]) so0_q[31-4*i -: 4] <= sbox(i, sin0[47-6*i -: 6]);
      if (sel1[7-i]) so1_q[31-4*i -: 4] <= sbox(i, sin1[47-6*i -: 6]);
    end
    fin0_q <= sel0 & ~dead;
    fin1_q <= sel1 & ~dead;
  end

  s_box_sequencer #(.SERIAL(0), .TIMEOUT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld0), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .err(er0), .err_clr(err_clr), .sbox_in(sin0),
    .sbox_select(sel0), .sbox_finish(fn0), .sbox_out(so0));

  s_box_sequencer #(.SERIAL(1), .TIMEOUT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld1), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .err(er1), .err_clr(err_clr), .sbox_in(sin1),
    .sbox_select(sel1), .sbox_finish(fn1), .sbox_out(so1));

  logic        ir, ov, er;
  logic [31:0] od;
  logic [47:0] sin;
  logic [7:0]  sel;
  assign ir  = mode ? ir1  : ir0;
  assign ov  = mode ? ov1  : ov0;
  assign er  = mode ? er1  : er0;
  assign od  = mode ? od1  : od0;
  assign sin = mode ? sin1 : sin0;
  assign sel = mode ? sel1 : sel0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic test_reset();
    for (int m = 0; m < 2; m++) begin
      mode = m[0];
      #1;
      n_cmp++;
      if ({ir, ov, er} !== 3'b100) begin
        n_err++;
        $display("FAIL reset_flags m=%0d got %b want 100", m, {ir, ov, er});
      end
      n_cmp++;
      if ({od, sin, sel} !== '0) begin
        n_err++;
        $display("FAIL reset_data m=%0d got %h/%h/%h want 0", m, od, sin, sel);
      end
    end
  endtask

  task automatic do_txn(input bit m, input logic [47:0] d, input int stall,
                        input int inj_c, input logic [7:0] inj_fin);
    logic [31:0] exp;
    logic [7:0]  esel;
    int c, lat;
    exp = ref_sub(d);
    lat = m ? 9 : 2;
    mode = m; in_valid = 1'b1; in_data = d; out_ready = 1'b0;
    n_cmp++;
    if (ir !== 1'b1) begin
      n_err++;
      $display("FAIL txn_idle got in_ready=%b want 1", ir);
    end
    c = 0;
    while (1) begin
      @(negedge clk); c++;
      if (c == 1) begin
        in_valid = 1'b0;
        in_data = {16'($urandom), 32'($urandom)};
      end
      if (m) esel = (c <= 8) ? (8'h80 >> (c - 1)) : 8'h00;
      else   esel = (c == 1) ? 8'hFF : 8'h00;
      n_cmp++;
      if (sel !== esel) begin
        n_err++;
        $display("FAIL select m=%0d c=%0d got %h want %h", m, c, sel, esel);
      end
      if (ov === 1'b1 || c >= 20) break;
      inj_f = (c == inj_c) ? inj_fin : 8'h00;
      inj_d = $urandom;
    end
    n_cmp++;
    if (c - 1 != lat) begin
      n_err++;
      $display("FAIL latency m=%0d got %0d want %0d", m, c - 1, lat);
    end
    n_cmp++;
    if (od !== exp) begin
      n_err++;
      $display("FAIL data m=%0d in=%h got %h want %h", m, d, od, exp);
    end
    n_cmp++;
    if (sin !== d) begin
      n_err++;
      $display("FAIL sbox_in_hold got %h want %h", sin, d);
    end
    for (int s = 0; s < stall; s++) begin
      inj_f = (c == inj_c) ? inj_fin : 8'h00;
      inj_d = $urandom;
      @(negedge clk); c++;
      n_cmp++;
      if (ov !== 1'b1 || od !== exp) begin
        n_err++;
        $display("FAIL stall_hold s=%0d got v=%b %h want v=1 %h", s, ov, od, exp);
      end
    end
    inj_f = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      n_err++;
      $display("FAIL post_handshake got rdy=%b v=%b want 1/0", ir, ov);
    end
  endtask

  task automatic test_back_to_back(input bit m);
    logic [31:0] q[$];
    logic [31:0] e;
    int p;
    p = m ? 11 : 4;
    mode = m; out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3 * p; k++) begin
      in_data = {16'($urandom), 32'($urandom)};
      if (k % p == 0) q.push_back(ref_sub(in_data));
      n_cmp++;
      if (ir !== (k % p == 0)) begin
        n_err++;
        $display("FAIL b2b_ready m=%0d k=%0d got %b", m, k, ir);
      end
      n_cmp++;
      if (ov !== (k % p == p - 1)) begin
        n_err++;
        $display("FAIL b2b_valid m=%0d k=%0d got %b", m, k, ov);
      end
      if (k % p == p - 1 && q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (od !== e) begin
          n_err++;
          $display("FAIL b2b_data m=%0d k=%0d got %h want %h", m, k, od, e);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end got rdy=%b v=%b want 1/0", ir, ov);
    end
  endtask

  task automatic test_timeout();
    mode = 1'b0; dead = 8'h02;
    in_valid = 1'b1; in_data = {16'($urandom), 32'($urandom)};
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (er !== (c == 6)) begin
        n_err++;
        $display("FAIL err_timing c=%0d got %b want %b", c, er, c == 6);
      end
    end
    n_cmp++;
    if ({ir, ov, sel} !== 10'b0) begin
      n_err++;
      $display("FAIL err_outputs got %b/%b/%h want 0/0/00", ir, ov, sel);
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (er !== 1'b1 || ir !== 1'b0) begin
      n_err++;
      $display("FAIL err_sticky got err=%b rdy=%b want 1/0", er, ir);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0; dead = 8'h00;
    n_cmp++;
    if (er !== 1'b0 || ir !== 1'b1) begin
      n_err++;
      $display("FAIL err_clear got err=%b rdy=%b want 0/1", er, ir);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_valid = 1'b1;
    in_data = {16'($urandom), 32'($urandom)};
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ir, ov, er} !== 3'b100 || {od, sin, sel} !== '0) begin
      n_err++;
      $display("FAIL mid_reset got %b %h %h %h want 100 0", {ir, ov, er}, od, sin, sel);
    end
    inj_f = 8'hFF; inj_d = $urandom;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inj_f = 8'h00;
    n_cmp++;
    if (ir !== 1'b1 || ov !== 1'b0 || od !== 32'h0) begin
      n_err++;
      $display("FAIL late_finish got rdy=%b v=%b %h want 1/0/0", ir, ov, od);
    end
    do_txn(1'b1, {16'($urandom), 32'($urandom)}, 0, 0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; err_clr = 1'b0; dead = '0; inj_f = '0; inj_d = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(1'b0, 48'h0, 0, 0, 8'h00);
    do_txn(1'b0, 48'hFFFFFFFFFFFF, 5, 3, 8'hFF);
    do_txn(1'b1, 48'h0, 0, 1, 8'h7F);
    do_txn(1'b1, {16'($urandom), 32'($urandom)}, 1, 4, 8'hC0);
    test_timeout();
    do_txn(1'b0, {16'($urandom), 32'($urandom)}, 0, 0, 8'h00);
    test_reset_mid();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    repeat (6)
      do_txn(1'($urandom_range(0, 1)), {16'($urandom), 32'($urandom)},
             $urandom_range(0, 2), 0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
